// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control unit for the 4-bit CPU.
// It fetches 8-bit instructions over a request/valid handshake and decodes
// them. ALU-class instructions drive registered operands and an opcode into
// an external combinational ALU. The ALU result is written back into a
// 4x4-bit register file.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   run_i          level; high permits instruction fetch
//   imem_addr_o    instruction address (always the PC)
//   imem_rd_o      one-cycle fetch request (high only in FETCH)
//   imem_data_i    instruction word, latched when imem_valid_i=1 in WAIT
//   imem_valid_i   instruction word valid
//   alu_a_o        ALU operand A (registered)
//   alu_b_o        ALU operand B (registered)
//   alu_op_o       ALU operation (ADD, SUB, AND, OR, XOR, PASS)
//   alu_result_i   ALU result, sampled in EXEC
//   alu_zero_i     ALU zero flag, sampled in EXEC
//   zflag_o        sticky zero flag, updated by ALU-class instructions only
//   halted_o       high in HALT state
//   fault_o        high in FAULT state (instruction fetch timed out)
//   dbg_sel_i      register-file debug read select
//   dbg_data_o     R[dbg_sel_i], combinational
module alu_sequencer #(
  parameter int unsigned TIMEOUT = 8  // max WAIT cycles, legal 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_i,
  output logic [3:0] imem_addr_o,
  output logic       imem_rd_o,
  input  logic [7:0] imem_data_i,
  input  logic       imem_valid_i,
  output logic [3:0] alu_a_o,
  output logic [3:0] alu_b_o,
  output logic [2:0] alu_op_o,
  input  logic [3:0] alu_result_i,
  input  logic       alu_zero_i,
  output logic       zflag_o,
  output logic       halted_o,
  output logic       fault_o,
  input  logic [1:0] dbg_sel_i,
  output logic [3:0] dbg_data_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_NEXT, S_HALT, S_FAULT
  } state_e;

  localparam logic [2:0] OP_PASS   = 3'b101;
  localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [3:0] cnt_q, cnt_d;
  logic       zflag_q, zflag_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic [3:0] rf_q [4];

  logic       rf_we;
  logic [1:0] rf_waddr;

  // Instruction fields
  logic [3:0] opc;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [3:0] imm;
  logic       is_alu;

  assign opc    = ir_q[7:4];
  assign rd     = ir_q[3:2];
  assign rs     = ir_q[1:0];
  assign imm    = ir_q[3:0];
  assign is_alu = (opc <= 4'd6);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run_i) state_d = S_FETCH;
      S_FETCH:  state_d = S_WAIT;
      // A valid word wins over the timeout, so a word that arrives on the
      // last allowed WAIT cycle is still accepted.
      S_WAIT: begin
        if (imem_valid_i)                    state_d = S_DECODE;
        else if (cnt_q + 4'd1 == TIMEOUT_C)  state_d = S_FAULT;
      end
      S_DECODE: begin
        if (is_alu)            state_d = S_EXEC;
        else if (opc == 4'hF)  state_d = S_HALT;
        else                   state_d = S_NEXT;
      end
      S_EXEC:   state_d = S_NEXT;
      S_NEXT:   state_d = run_i ? S_FETCH : S_IDLE;
      default:  state_d = state_q;  // HALT and FAULT are left only by reset
    endcase
  end

  // State-decoded outputs
  always_comb begin
    imem_rd_o = (state_q == S_FETCH);
    halted_o  = (state_q == S_HALT);
    fault_o   = (state_q == S_FAULT);
  end

  // Datapath next-state
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    cnt_d    = cnt_q;
    zflag_d  = zflag_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    rf_we    = 1'b0;
    rf_waddr = rd;
    case (state_q)
      S_FETCH: cnt_d = 4'd0;
      S_WAIT: begin
        if (imem_valid_i) ir_d  = imem_data_i;
        else              cnt_d = cnt_q + 4'd1;
      end
      S_DECODE: begin
        if (opc <= 4'd4) begin
          alu_a_d  = rf_q[rd];
          alu_b_d  = rf_q[rs];
          alu_op_d = opc[2:0];
        end else if (opc == 4'd5) begin  // MOV
          alu_a_d  = rf_q[rs];
          alu_b_d  = 4'd0;
          alu_op_d = OP_PASS;
        end else if (opc == 4'd6) begin  // LDI
          alu_a_d  = imm;
          alu_b_d  = 4'd0;
          alu_op_d = OP_PASS;
        end else if (opc == 4'd7) begin  // JMP
          pc_d = imm;
        end else if (opc == 4'd8) begin  // JZ
          pc_d = zflag_q ? imm : pc_q + 4'd1;
        end else if (opc != 4'hF) begin  // NOP; HALT keeps PC
          pc_d = pc_q + 4'd1;
        end
      end
      S_EXEC: begin
        rf_we    = 1'b1;
        rf_waddr = (opc == 4'd6) ? 2'd0 : rd;  // LDI always targets R0
        zflag_d  = alu_zero_i;
        pc_d     = pc_q + 4'd1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= 4'd0;
      ir_q     <= 8'd0;
      cnt_q    <= 4'd0;
      zflag_q  <= 1'b0;
      alu_a_q  <= 4'd0;
      alu_b_q  <= 4'd0;
      alu_op_q <= 3'd0;
      for (int i = 0; i < 4; i++) rf_q[i] <= 4'd0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      zflag_q  <= zflag_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      if (rf_we) rf_q[rf_waddr] <= alu_result_i;
    end
  end

  assign imem_addr_o = pc_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_op_o    = alu_op_q;
  assign zflag_o     = zflag_q;
  assign dbg_data_o  = rf_q[dbg_sel_i];

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer. It serves instructions on demand, models the
// ALU, and tracks architectural state with an instruction-level model.
module tb_alu_sequencer;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run = 1'b0;
  logic [3:0] imem_addr;
  logic       imem_rd;
  logic [7:0] imem_data = 8'd0;
  logic       imem_valid = 1'b0;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       alu_zero, zflag, halted, fault;
  logic [1:0] dbg_sel = 2'd0;
  logic [3:0] dbg_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Architectural model
  int m_pc, m_z, m_a, m_b, m_op, m_halted;
  int m_r[4];
  int exp_gap = 0;
  int last_fetch = 0;

  alu_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run),
    .imem_addr_o(imem_addr), .imem_rd_o(imem_rd),
    .imem_data_i(imem_data), .imem_valid_i(imem_valid),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .alu_result_i(alu_result), .alu_zero_i(alu_zero),
    .zflag_o(zflag), .halted_o(halted), .fault_o(fault),
    .dbg_sel_i(dbg_sel), .dbg_data_o(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External combinational ALU
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      3'd4:    alu_result = alu_a ^ alu_b;
      3'd5:    alu_result = alu_a;
      default: alu_result = 4'd0;
    endcase
    alu_zero = (alu_result == 4'd0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_z = 0; m_a = 0; m_b = 0; m_op = 0; m_halted = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    exp_gap = 0;
  endtask

  task automatic model_apply(input logic [7:0] ins);
    int opc, rd, rs, imm, a, b, res;
    opc = int'(ins[7:4]); rd = int'(ins[3:2]); rs = int'(ins[1:0]); imm = int'(ins[3:0]);
    if (opc <= 6) begin
      if (opc == 5)      begin a = m_r[rs]; b = 0; end
      else if (opc == 6) begin a = imm; b = 0; rd = 0; end
      else               begin a = m_r[rd]; b = m_r[rs]; end
      case (opc)
        0:       res = (a + b) % 16;
        1:       res = (a - b + 16) % 16;
        2:       res = a & b;
        3:       res = a | b;
        4:       res = a ^ b;
        default: res = a;
      endcase
      m_r[rd] = res;
      m_z = (res == 0) ? 1 : 0;
      m_a = a; m_b = b;
      m_op = (opc >= 5) ? 5 : opc;
      m_pc = (m_pc + 1) % 16;
    end else if (opc == 7) m_pc = imm;
    else if (opc == 8)     m_pc = (m_z == 1) ? imm : (m_pc + 1) % 16;
    else if (opc == 15)    m_halted = 1;
    else                   m_pc = (m_pc + 1) % 16;
  endtask

  task automatic check_arch(input string tag);
    chk({tag, " pc"}, imem_addr, m_pc);
    chk({tag, " zflag"}, zflag, m_z);
    chk({tag, " alu_a"}, alu_a, m_a);
    chk({tag, " alu_b"}, alu_b, m_b);
    chk({tag, " alu_op"}, alu_op, m_op);
    chk({tag, " halted"}, halted, m_halted);
    chk({tag, " fault"}, fault, 0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk($sformatf("%s r%0d", tag, i), dbg_data, m_r[i]);
    end
  endtask

  // Entered at a negedge; returns at a negedge with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    imem_valid = 1'b0;
    #1;
    model_reset();
    chk("rst imem_rd", imem_rd, 0);
    check_arch("rst");
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn reset");
  endtask

  task automatic wait_fetch(output bit ok);
    for (int i = 0; i < 40 && imem_rd !== 1'b1; i++) @(negedge clk);
    imem_valid = 1'b0;
    ok = (imem_rd === 1'b1);
    chk("fetch_seen", imem_rd, 1);
    if (ok && exp_gap > 0) chk("fetch_gap", 8'(cyc - last_fetch), 8'(exp_gap));
    last_fetch = cyc;
  endtask

  // mode 0: normal; 1: drop run during EXEC (DECODE for non-ALU); 2: reset in EXEC
  task automatic exec_one(input logic [7:0] ins, input int w, input int mode);
    bit ok, is_alu;
    wait_fetch(ok);
    if (!ok) return;
    check_arch("pre");
    @(negedge clk);
    chk("rd_pulse", imem_rd, 0);
    for (int k = 1; k < w; k++) begin
      imem_data = 8'($urandom);
      @(negedge clk);
    end
    imem_valid = 1'b1;
    imem_data  = ins;
    @(negedge clk);
    imem_valid = 1'($urandom_range(0, 1));
    imem_data  = 8'($urandom);
    is_alu = (ins[7:4] <= 4'd6);
    $display("txn ins=%02h wait=%0d mode=%0d pc=%0d", ins, w, mode, m_pc);
    if (mode == 2) begin
      @(negedge clk);
      do_reset();
      return;
    end
    model_apply(ins);
    if (mode == 1) begin
      if (is_alu) @(negedge clk);
      run = 1'b0;
      exp_gap = 0;
    end else begin
      exp_gap = (ins[7:4] == 4'hF) ? 0 : (is_alu ? w + 4 : w + 3);
    end
  endtask

  task automatic idle_check();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("idle_no_fetch", imem_rd, 0);
    end
    check_arch("idle");
    run = 1'b1;
  endtask

  task automatic halt_check();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("halt_no_fetch", imem_rd, 0);
    end
    check_arch("halt");
  endtask

  task automatic expect_fault();
    bit ok;
    wait_fetch(ok);
    if (!ok) return;
    check_arch("pre_fault");
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      imem_data = 8'($urandom);
      if (k == TO) chk("fault_early", fault, 0);
    end
    @(negedge clk);
    chk("fault_set", fault, 1);
    chk("fault_halted", halted, 0);
    for (int k = 0; k < 5; k++) begin
      imem_valid = 1'b1;
      @(negedge clk);
      chk("fault_no_fetch", imem_rd, 0);
      chk("fault_hold", fault, 1);
    end
    imem_valid = 1'b0;
    $display("txn fault observed");
  endtask

  initial begin
    bit ok;
    @(negedge clk);
    do_reset();
    // Reset state holds while run is low
    @(negedge clk);
    chk("idle_rd", imem_rd, 0);
    run = 1'b1;

    // Program: LDI 5; MOV R1,R0; LDI 3; ADD R1,R0; HALT
    exec_one(8'h65, 1, 0);
    exec_one(8'h54, 1, 0);
    exec_one(8'h63, 1, 0);
    exec_one(8'h04, 1, 0);
    exec_one(8'hF0, 1, 0);
    halt_check();
    chk("p1 R1", m_r[1], 8);  // model sanity against hand-computed value
    do_reset();

    // Zero flag and JZ taken / not taken
    exec_one(8'h67, 1, 0);
    exec_one(8'h58, 2, 0);
    exec_one(8'h18, 1, 0);
    exec_one(8'h8A, 3, 0);
    exec_one(8'h63, 1, 0);
    exec_one(8'h85, 1, 0);

    // PC wrap and JMP without ALU activity
    exec_one(8'h7F, 1, 0);
    exec_one(8'h90, 1, 0);
    exec_one(8'h73, 1, 0);

    // Drop run during EXEC of ADD, then resume
    exec_one(8'h04, 1, 1);
    idle_check();

    // Valid on the last allowed WAIT cycle, then a true timeout
    exec_one(8'h6B, TO, 0);
    exec_one(8'h9C, 1, 0);
    expect_fault();
    do_reset();

    // Reset during WAIT, and reset during EXEC
    exec_one(8'h6C, 1, 0);
    exec_one(8'h5C, 1, 0);
    wait_fetch(ok);
    @(negedge clk);
    do_reset();
    exec_one(8'h69, 1, 0);
    exec_one(8'h00, 1, 2);

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      logic [7:0] ins;
      ins = 8'($urandom);
      if (ins[7:4] == 4'hF) ins[7:4] = 4'($urandom_range(0, 6));
      if (($urandom % 8) == 0) begin
        exec_one(ins, int'($urandom_range(1, TO)), 1);
        idle_check();
      end else begin
        exec_one(ins, int'($urandom_range(1, TO)), 0);
      end
    end
    exec_one(8'hF0, int'($urandom_range(1, TO)), 0);
    halt_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control unit that drives the combinational ALU for the 4-bit CPU.
- Fetches 8-bit instructions from a handshaked instruction memory and decodes them.
- Drives ALU operands and opcode, then writes the ALU result back into an internal 4x4-bit register file.
- Keeps a sticky zero flag for conditional jumps and provides halt, fault and debug visibility.

Parameters:
TIMEOUT, 8, maximum WAIT cycles allowed for imem_valid before entering FAULT (legal range 1..15).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; high permits instruction fetch
imem_addr  output  4  instruction address (equals PC)
imem_rd  output  1  one-cycle fetch request pulse
imem_data  input  8  instruction word, sampled only when imem_valid=1 in WAIT
imem_valid  input  1  instruction word valid
alu_a  output  4  ALU operand A (registered)
alu_b  output  4  ALU operand B (registered)
alu_op  output  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASS
alu_result  input  4  ALU result
alu_zero  input  1  ALU zero flag
zflag  output  1  stored zero flag
halted  output  1  high in HALT state
fault  output  1  high in FAULT state
dbg_sel  input  2  register-file read select
dbg_data  output  4  R[dbg_sel], combinational

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: PC=0, R0..R3=0, zflag=0, alu_a=0, alu_b=0, alu_op=000, imem_rd=0, halted=0, fault=0, state=IDLE.
- Reset asserted mid-instruction aborts the instruction immediately; no partial writeback.
- Instruction format: [7:4] opcode, [3:2] rd, [1:0] rs, [3:0] imm/addr.
- Opcodes 0..4 (ADD, SUB, AND, OR, XOR): a=R[rd], b=R[rs], op=opcode[2:0], R[rd]<=result.
- Opcode 5, MOV: a=R[rs], b=0, op=PASS, R[rd]<=result.
- Opcode 6, LDI: a=imm, b=0, op=PASS, R0<=result.
- Opcode 7, JMP: PC<=addr.
- Opcode 8, JZ: PC<=addr if zflag=1, else PC+1.
- Opcode F, HALT.
- Opcodes 9..E: NOP (PC+1).
- State machine:
  - IDLE: wait for run=1, then go to FETCH.
  - FETCH: imem_rd=1 for exactly this cycle, imem_addr=PC; go to WAIT and clear the timeout counter.
  - WAIT: if imem_valid, latch IR and go to DECODE. Otherwise increment the counter; when the counter reaches TIMEOUT, go to FAULT. A valid arriving on the TIMEOUT-th WAIT cycle is accepted.
  - DECODE:
    - ALU-class instruction (0..6): register alu_a/alu_b/alu_op, go to EXEC.
    - JMP/JZ/NOP: update PC, go to NEXT.
    - HALT: go to HALT; PC is not incremented.
  - EXEC: sample alu_result/alu_zero; write the destination register, zflag<=alu_zero, PC<=PC+1; go to NEXT.
  - NEXT: if run=1 go to FETCH, else go to IDLE. PC and registers are preserved.
  - HALT, FAULT: terminal; exit only via reset.
- Only ALU-class instructions update zflag; JMP, JZ, NOP and HALT leave it unchanged.
- alu_a, alu_b and alu_op hold their last values outside DECODE/EXEC.
- Latency: ALU-class instruction takes 4 cycles plus (WAIT cycles − 1); jump/NOP takes 3 cycles plus the same.
- PC wraps 15→0 on increment.
- imem_valid outside WAIT is ignored. imem_data is ignored when imem_valid=0.
- run deasserted mid-instruction: the instruction completes, then the block parks in IDLE.
- Register writes occur only in EXEC. dbg_data reflects a write on the following cycle.

Test Plan:
1. Memory returns valid 1 cycle after imem_rd. Program LDI 5; MOV R1,R0; LDI 3; ADD R1,R0; HALT → R1=8, zflag=0, halted=1, PC=4.
2. Program LDI 7; MOV R2,R0; SUB R2,R0 → R2=0, zflag=1. Then JZ 0xA → next imem_addr=0xA. Repeat with zflag=0 → imem_addr=PC+1.
3. TIMEOUT=8, imem_valid never asserted → fault=1 after the 8th WAIT cycle, imem_rd stays 0 afterwards. With valid on WAIT cycle 8, the instruction is accepted and no fault occurs.
4. Program of NOPs starting at PC=15 → next fetch at addr 0. JMP 3 → imem_addr=3 and no ALU activity.
5. Drop run during EXEC of ADD → writeback completes, state goes to IDLE with PC incremented. Re-raise run → fetch resumes at the saved PC.
6. Assert rst_n=0 during WAIT, then release → all outputs at reset values, PC=0, registers 0, no write from the aborted instruction.
